// File: rtl/ub_pkg.sv
// Shared defaults and state encoding for the unified lane buffer.
//   UB_DATA_W / UB_DEPTH / UB_LANES : default word width, word count, lanes per beat
//   ub_state_e                      : zeroing-sweep sequencer states
package ub_pkg;

  localparam int UB_DATA_W = 32;
  localparam int UB_DEPTH  = 64;
  localparam int UB_LANES  = 4;

  typedef enum logic {
    UB_IDLE  = 1'b0,
    UB_CLEAR = 1'b1
  } ub_state_e;

endpackage

// File: rtl/ub_clear_seq.sv
// Zeroing-sweep sequencer: walks the memory one row (LANES words) per cycle.
//   clk, reset_n : clock, async active-low reset (aborts a sweep in progress)
//   clear_i      : start a sweep; ignored while one is running
//   busy_o       : high exactly while rows are being zeroed
//   row_addr_o   : base word address of the row zeroed this cycle
//
// state    | meaning
// ---------+---------------------------------------------------
// UB_IDLE  | no sweep; waiting for clear_i
// UB_CLEAR | zeroing row at row_addr_o; leaves after last row
module ub_clear_seq
  import ub_pkg::*;
#(
  parameter int DEPTH  = UB_DEPTH,
  parameter int LANES  = UB_LANES,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] row_addr_o
);

  localparam int ROWS  = DEPTH / LANES;
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  ub_state_e         state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] row_addr_q;
  logic [CNT_W-1:0]  rows_left_q;

  // rows_left_q counts down to zero; the row at zero is the final one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= UB_IDLE;
      busy_q      <= 1'b0;
      row_addr_q  <= '0;
      rows_left_q <= '0;
    end else begin
      case (state_q)
        UB_IDLE: begin
          if (clear_i) begin
            state_q     <= UB_CLEAR;
            busy_q      <= 1'b1;
            row_addr_q  <= '0;
            rows_left_q <= CNT_W'(ROWS - 1);
          end
        end
        UB_CLEAR: begin
          if (rows_left_q == '0) begin
            state_q <= UB_IDLE;
            busy_q  <= 1'b0;
          end else begin
            rows_left_q <= rows_left_q - CNT_W'(1);
            row_addr_q  <= row_addr_q + ADDR_W'(LANES);
          end
        end
        default: begin
          state_q <= UB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign row_addr_o = row_addr_q;

endmodule

// File: rtl/param_unified_buffer.sv
// Multi-lane word buffer: LANES-wide writes (masked, auto or explicit base) and
// LANES-wide reads with one cycle latency, addresses wrapping modulo DEPTH,
// plus a whole-memory zeroing sweep.
//   clk, reset_n                 : clock, async active-low reset (memory not reset)
//   wr_valid/wr_ready            : write handshake; wr_auto picks wr_ptr vs wr_addr
//   wr_addr, wr_mask, wr_data    : explicit base, per-lane enable, lane-packed data
//   rd_valid/rd_ready, rd_addr   : read handshake and base address
//   rd_data, rd_data_valid       : registered read result and its one-cycle pulse
//   clear, clear_busy            : start zeroing sweep / sweep running
//   wr_ptr                       : internal write pointer
// Build option: define UB_BYPASS_EN to forward same-cycle write data to an
// overlapping read; otherwise such a read returns the old contents.
module param_unified_buffer
  import ub_pkg::*;
#(
  parameter int DATA_W = UB_DATA_W,
  parameter int DEPTH  = UB_DEPTH,
  parameter int LANES  = UB_LANES,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic                    wr_auto,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [LANES-1:0]        wr_mask,
  input  logic [LANES*DATA_W-1:0] wr_data,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [LANES*DATA_W-1:0] rd_data,
  output logic                    rd_data_valid,
  input  logic                    clear,
  output logic                    clear_busy,
  output logic [ADDR_W-1:0]       wr_ptr
);

  localparam int              AW1     = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_X = AW1'(DEPTH);

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [LANES*DATA_W-1:0] rd_data_q, rd_data_d;
  logic                    rd_valid_q;
  logic                    busy;
  logic [ADDR_W-1:0]       clr_row;
  logic                    wr_fire, rd_fire, clr_start;
  logic [ADDR_W-1:0]       wr_base;
  logic [ADDR_W-1:0]       wr_lane_addr [LANES];
  logic [ADDR_W-1:0]       rd_lane_addr [LANES];

  // (base + off) mod DEPTH without requiring DEPTH to be a power of two
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] base,
                                                 input int unsigned       off);
    logic [ADDR_W:0] sum;
    sum = {1'b0, base} + AW1'(off);
    if (sum >= DEPTH_X) sum = sum - DEPTH_X;
    return sum[ADDR_W-1:0];
  endfunction

  ub_clear_seq #(
    .DEPTH  (DEPTH),
    .LANES  (LANES),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (clear),
    .busy_o     (busy),
    .row_addr_o (clr_row)
  );

  // clear beats any same-cycle access, so ready drops combinationally on clear
  assign wr_ready  = !busy && !clear;
  assign rd_ready  = !busy && !clear;
  assign wr_fire   = wr_valid && wr_ready;
  assign rd_fire   = rd_valid && rd_ready;
  assign clr_start = clear && !busy;
  assign wr_base   = wr_auto ? wr_ptr_q : wr_addr;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      wr_lane_addr[i] = wrap_add(wr_base, i);
      rd_lane_addr[i] = wrap_add(rd_addr, i);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (clr_start)    wr_ptr_d = '0;
    else if (wr_fire) wr_ptr_d = wrap_add(wr_base, LANES);
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_fire) begin
      for (int i = 0; i < LANES; i++) begin
        rd_data_d[i*DATA_W +: DATA_W] = mem_q[rd_lane_addr[i]];
`ifdef UB_BYPASS_EN
        for (int j = 0; j < LANES; j++) begin
          if (wr_fire && wr_mask[j] && (wr_lane_addr[j] == rd_lane_addr[i]))
            rd_data_d[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
        end
`endif
      end
    end
  end

  // storage is deliberately left out of reset; software zeroes it with clear
  always_ff @(posedge clk) begin
    if (busy) begin
      for (int i = 0; i < LANES; i++)
        mem_q[clr_row + ADDR_W'(i)] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < LANES; i++)
        if (wr_mask[i]) mem_q[wr_lane_addr[i]] <= wr_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_fire;
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign clear_busy    = busy;
  assign wr_ptr        = wr_ptr_q;

endmodule

// File: doc/param_unified_buffer.md
PARAM_UNIFIED_BUFFER -- requirements
Module: param_unified_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bit width of one word.
REQ-002 SHALL have parameter DEPTH, default 64, number of words; SHALL be a multiple of LANES.
REQ-003 SHALL have parameter LANES, default 4, words per write or read beat.
REQ-004 SHALL have parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 wr_valid  input  1  write beat offered.
REQ-008 wr_ready  output  1  write beat can be accepted.
REQ-009 wr_auto  input  1  1 = use internal write pointer, 0 = use wr_addr.
REQ-010 wr_addr  input  ADDR_W  base word address for explicit writes.
REQ-011 wr_mask  input  LANES  per-lane write enable.
REQ-012 wr_data  input  LANES*DATA_W  lane i in bits [i*DATA_W +: DATA_W].
REQ-013 rd_valid  input  1  read request offered.
REQ-014 rd_ready  output  1  read request can be accepted.
REQ-015 rd_addr  input  ADDR_W  base word address for reads.
REQ-016 rd_data  output  LANES*DATA_W  read result, same lane packing.
REQ-017 rd_data_valid  output  1  one-cycle pulse marking new rd_data.
REQ-018 clear  input  1  start a whole-memory zeroing sweep.
REQ-019 clear_busy  output  1  sweep in progress.
REQ-020 wr_ptr  output  ADDR_W  current internal write pointer.

Function
REQ-021 Write accepted when wr_valid && wr_ready; lane i with wr_mask[i]=1 SHALL write mem[(base+i) mod DEPTH]; masked lanes unchanged.
REQ-022 Base = wr_ptr if wr_auto else wr_addr.
REQ-023 On every accepted write, wr_ptr SHALL become (base+LANES) mod DEPTH, regardless of wr_auto or mask.
REQ-024 Read accepted when rd_valid && rd_ready; rd_data lane i SHALL equal mem[(rd_addr+i) mod DEPTH] on the next cycle, with rd_data_valid=1 that cycle; latency exactly 1.
REQ-025 rd_data SHALL hold its last value until the next accepted read.
REQ-026 Write and read accepted in the same cycle to an overlapping word: read SHALL return the pre-write value (forwarding off, see REQ-036).
REQ-027 FSM states IDLE, CLEAR; IDLE->CLEAR when clear=1; CLEAR->IDLE after the last row is written.
REQ-028 In CLEAR, one row of LANES words SHALL be zeroed per cycle at addresses 0, LANES, 2*LANES, ...; sweep SHALL take DEPTH/LANES cycles.
REQ-029 wr_ready = rd_ready = !clear_busy; clear_busy=1 exactly while in CLEAR.
REQ-030 On entering CLEAR, wr_ptr SHALL reset to 0.
REQ-031 clear asserted while already in CLEAR SHALL be ignored; clear and wr_valid in the same IDLE cycle: clear wins, write not accepted (wr_ready combinationally 0 when clear=1).

Reset
REQ-032 reset_n low SHALL asynchronously force state IDLE, wr_ptr=0, rd_data=0, rd_data_valid=0, clear_busy=0.
REQ-033 Memory contents SHALL NOT be reset; software issues clear.
REQ-034 Reset during CLEAR SHALL abort the sweep; partially cleared rows remain zero, others are undefined.

Configuration
REQ-035 Macro UB_BYPASS_EN selects read forwarding.
REQ-036 With UB_BYPASS_EN defined, for the case in REQ-026 each overlapping, unmasked lane SHALL return the newly written data; without it, the old value per REQ-026.

Structure
REQ-037 Shared package ub_pkg SHALL hold default DATA_W/DEPTH/LANES constants and the FSM state enum.
REQ-038 One sub-module ub_clear_seq SHALL implement the CLEAR FSM and row counter.

Verification
REQ-039 Reset, clear; write auto with data {1,2,3,4}, mask 4'hF -> wr_ptr=4; read addr 0 -> next cycle rd_data={1,2,3,4}, rd_data_valid=1.
REQ-040 Explicit write addr 62, data {A,B,C,D} -> mem[62]=A, mem[63]=B, mem[0]=C, mem[1]=D; wr_ptr=2.
REQ-041 Write mask 4'b0101 data {9,9,9,9} at 8 over prior {5,6,7,8} -> read 8 returns {9,6,9,8}.
REQ-042 Same-cycle write {7,7,7,7} and read at 16 over zeros -> {0,0,0,0} without UB_BYPASS_EN, {7,7,7,7} with it.
REQ-043 clear with wr_valid=1 -> clear_busy high exactly 16 cycles, wr_ready=rd_ready=0 meanwhile, write not accepted, all reads afterwards return 0.
REQ-044 reset_n low mid-CLEAR at cycle 5 -> clear_busy=0, wr_ptr=0, rd_data_valid=0 immediately, rows 0-4 read as 0.
